// File: rtl/departing_ctrl_pkg.sv
// Shared airlock definitions: 3-bit state encodings, default cycle counts and the
// state-to-command decode. The arrival controller imports this same package.
package departing_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESSURIZE  = 3'd1,
        ST_OPEN_INNER  = 3'd2,
        ST_BOARD       = 3'd3,
        ST_CLOSE_INNER = 3'd4,
        ST_EVACUATE    = 3'd5,
        ST_OPEN_OUTER  = 3'd6,
        ST_EXIT        = 3'd7
    } state_e;

    localparam int DEF_BOARD_CYCLES   = 5;
    localparam int DEF_EXIT_CYCLES    = 5;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_TW             = 5;

    typedef struct packed {
        logic busy;
        logic pressurize;
        logic evacuate;
        logic open_inner;
        logic open_outer;
    } cmd_t;

    function automatic cmd_t decode_cmd(state_e s);
        cmd_t c;
        c            = '0;
        c.busy       = (s != ST_IDLE);
        c.pressurize = (s == ST_PRESSURIZE);
        c.evacuate   = (s == ST_EVACUATE);
        c.open_inner = (s == ST_OPEN_INNER) || (s == ST_BOARD);
        c.open_outer = (s == ST_OPEN_OUTER) || (s == ST_EXIT);
        return c;
    endfunction

    function automatic logic is_sensor_wait(state_e s);
        return (s == ST_PRESSURIZE) || (s == ST_OPEN_INNER) || (s == ST_CLOSE_INNER) ||
               (s == ST_EVACUATE)   || (s == ST_OPEN_OUTER);
    endfunction

    // A state that must last n cycles loads n-1 and leaves when the count hits 0;
    // n = 0 behaves as 1.
    function automatic int hold_load(int n);
        return (n <= 1) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/departing_ctrl_timer.sv
// depart_timer: loadable down-counter that saturates at zero and flags expiry.
module depart_timer
    import departing_ctrl_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [TW-1:0] value,
    output logic          expired
);
    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/departing_ctrl.sv
// Departure airlock sequencer: interior -> chamber -> vacuum, interlocked with arrival.
// Define DEPART_TIMEOUT_EN to add a watchdog on every sensor-wait state.
module departing_ctrl
    import departing_ctrl_pkg::*;
#(
    parameter int BOARD_CYCLES   = DEF_BOARD_CYCLES,
    parameter int EXIT_CYCLES    = DEF_EXIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TW             = DEF_TW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       departCtrl,
    input  logic       arriving,
    input  logic       innerDoor,
    input  logic       outerDoor,
    input  logic       pressurized,
    input  logic       evacuated,
    output logic       departing,
    output logic       pressurizeReq,
    output logic       evacuateReq,
    output logic       openInner,
    output logic       openOuter,
    output logic       fault,
    output logic [0:2] debugState
);
    localparam logic [TW-1:0] BOARD_LOAD   = TW'(hold_load(BOARD_CYCLES));
    localparam logic [TW-1:0] EXIT_LOAD    = TW'(hold_load(EXIT_CYCLES));
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(hold_load(TIMEOUT_CYCLES));

    state_e        state, nxt;
    cmd_t          cmd;
    logic          abort, fault_q;
    logic          tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0] tmr_value;

    always_comb begin
        // NOTE: nxt and abort get defaults first, so no branch can infer a latch.
        nxt   = state;
        abort = 1'b0;
        case (state)
            ST_IDLE:        if (departCtrl && !arriving) nxt = ST_PRESSURIZE;
            ST_PRESSURIZE:  if (pressurized)             nxt = ST_OPEN_INNER;
            ST_OPEN_INNER:  if (innerDoor)               nxt = ST_BOARD;
            ST_BOARD:       if (tmr_expired)             nxt = ST_CLOSE_INNER;
            ST_CLOSE_INNER: if (!innerDoor)              nxt = ST_EVACUATE;
            ST_EVACUATE:    if (evacuated)               nxt = ST_OPEN_OUTER;
            ST_OPEN_OUTER:  if (outerDoor)               nxt = ST_EXIT;
            ST_EXIT:        if (tmr_expired)             nxt = ST_IDLE;
            default:                                     nxt = ST_IDLE;
        endcase
`ifdef DEPART_TIMEOUT_EN
        if (is_sensor_wait(state) && nxt == state && tmr_expired) begin
            nxt   = ST_IDLE;
            abort = 1'b1;
        end
`endif
    end

    // Every state change reloads the timer with the budget of the state being entered.
    assign tmr_load  = (nxt != state);
    assign tmr_value = (nxt == ST_BOARD) ? BOARD_LOAD :
                       (nxt == ST_EXIT)  ? EXIT_LOAD  : TIMEOUT_LOAD;
`ifdef DEPART_TIMEOUT_EN
    assign tmr_en = (state != ST_IDLE);
`else
    assign tmr_en = (state == ST_BOARD) || (state == ST_EXIT);
`endif

    depart_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // NOTE: state and outputs share one clocked block with non-blocking updates;
    // outputs are decoded from nxt so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cmd     <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= nxt;
            cmd     <= decode_cmd(nxt);
            fault_q <= abort;
        end
    end

    assign departing     = cmd.busy;
    assign pressurizeReq = cmd.pressurize;
    assign evacuateReq   = cmd.evacuate;
    assign openInner     = cmd.open_inner;
    assign openOuter     = cmd.open_outer;
    assign fault         = fault_q;
    assign debugState    = state;
endmodule

// File: tb/tb_departing_ctrl.sv
// Scoreboard bench for departing_ctrl: a phase-table reference model predicts every
// cycle's outputs; a monitor pops predictions and compares them with the DUT.
module tb_departing_ctrl;
    localparam int BOARD_N = 5;
    localparam int EXIT_N  = 5;
    localparam int TMO_N   = 16;
    localparam int TW_N    = 5;
`ifdef DEPART_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, departCtrl, arriving, innerDoor, outerDoor, pressurized, evacuated;
    logic       departing, pressurizeReq, evacuateReq, openInner, openOuter, fault;
    logic [0:2] debugState;

    departing_ctrl #(
        .BOARD_CYCLES(BOARD_N), .EXIT_CYCLES(EXIT_N), .TIMEOUT_CYCLES(TMO_N), .TW(TW_N)
    ) dut (
        .clk(clk), .rst(rst), .departCtrl(departCtrl), .arriving(arriving),
        .innerDoor(innerDoor), .outerDoor(outerDoor), .pressurized(pressurized),
        .evacuated(evacuated), .departing(departing), .pressurizeReq(pressurizeReq),
        .evacuateReq(evacuateReq), .openInner(openInner), .openOuter(openOuter),
        .fault(fault), .debugState(debugState)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase = sequence position 0..7, elapsed = cycles spent in it.
    int m_phase = 0, m_elapsed = 0;
    bit m_fault = 1'b0;

    function automatic bit sensor_ok(int ph, bit pr, bit ev, bit inr, bit outr);
        case (ph)
            1: return pr;
            2: return inr;
            4: return !inr;
            5: return ev;
            6: return outr;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit dc, input bit arr,
                              input bit pr, input bit ev, input bit inr, input bit outr);
        int dur;
        m_fault = 1'b0;
        if (!r) begin
            m_phase = 0; m_elapsed = 0;
        end else if (m_phase == 0) begin
            if (dc && !arr) begin m_phase = 1; m_elapsed = 1; end
        end else if (m_phase == 3 || m_phase == 7) begin
            dur = (m_phase == 3) ? BOARD_N : EXIT_N;
            if (dur < 1) dur = 1;
            if (m_elapsed >= dur) begin m_phase = (m_phase + 1) % 8; m_elapsed = 1; end
            else m_elapsed++;
        end else if (sensor_ok(m_phase, pr, ev, inr, outr)) begin
            m_phase++; m_elapsed = 1;
        end else if (TIMEOUT_ON && m_elapsed >= TMO_N) begin
            m_phase = 0; m_elapsed = 0; m_fault = 1'b1;
        end else begin
            m_elapsed++;
        end
    endtask

    function automatic logic [8:0] exp_vec();
        return {m_phase != 0, m_phase == 1, m_phase == 5, m_phase == 2 || m_phase == 3,
                m_phase == 6 || m_phase == 7, m_fault, 3'(m_phase)};
    endfunction

    function automatic logic [8:0] act_vec();
        return {departing, pressurizeReq, evacuateReq, openInner, openOuter, fault, debugState};
    endfunction

    // Plant: doors and chamber pressure follow the model's commands after pd cycles.
    int pd = 2, c_in = 0, c_out = 0, c_lvl = 0;
    bit lvl = 1'b0, in_s = 1'b0, out_s = 1'b0, stuck_ev = 1'b0, rand_sens = 1'b0;

    task automatic plant_advance();
        bit want_in, want_out;
        want_in  = (m_phase == 2 || m_phase == 3);
        want_out = (m_phase == 6 || m_phase == 7);
        if (want_in != in_s) begin
            c_in++;
            if (c_in >= pd) begin in_s = want_in; c_in = 0; end
        end else c_in = 0;
        if (want_out != out_s) begin
            c_out++;
            if (c_out >= pd) begin out_s = want_out; c_out = 0; end
        end else c_out = 0;
        if ((m_phase == 1 && !lvl) || (m_phase == 5 && lvl)) begin
            c_lvl++;
            if (c_lvl >= pd) begin lvl = !lvl; c_lvl = 0; end
        end else c_lvl = 0;
    endtask

    task automatic step(input bit r, input bit dc, input bit arr);
        bit pr, ev, inr, outr;
        plant_advance();
        if (rand_sens) begin
            pr = 1'($urandom_range(0, 1)); ev   = 1'($urandom_range(0, 1));
            inr = 1'($urandom_range(0, 1)); outr = 1'($urandom_range(0, 1));
        end else begin
            pr = lvl; ev = !lvl && !stuck_ev; inr = in_s; outr = out_s;
        end
        rst = r; departCtrl = dc; arriving = arr;
        pressurized = pr; evacuated = ev; innerDoor = inr; outerDoor = outr;
        model_step(r, dc, arr, pr, ev, inr, outr);
        exp_q.push_back(exp_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target, input int max_steps, input string name);
        int n = 0;
        while (debugState != 3'(target) && n < max_steps) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        check(name, debugState, target);
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) check("cycle", act_vec(), exp_q.pop_front());
    end

    initial begin
        int q[$];
        int seq, nvis, board_len, exit_len, busy_bad, gap, after, evac_len, fault_cnt;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("reset_state", act_vec(), 9'd0);

        // Nominal departure with two-cycle sensor responses.
        pd = 2; q = {}; busy_bad = 0;
        q.push_back(debugState);
        step(1'b1, 1'b1, 1'b0);
        q.push_back(debugState);
        for (int i = 0; i < 60 && debugState != 3'd0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            q.push_back(debugState);
            if (debugState != 3'd0 && !departing) busy_bad++;
        end
        seq = 0; nvis = 0; board_len = 0; exit_len = 0;
        foreach (q[i]) begin
            if (i == 0 || q[i] != q[i-1]) begin seq = (seq << 3) | q[i]; nvis++; end
            if (q[i] == 3) board_len++;
            if (q[i] == 7) exit_len++;
        end
        check("visit_seq", seq, 27'o012345670);
        check("visit_count", nvis, 9);
        check("board_len", board_len, BOARD_N);
        check("exit_len", exit_len, EXIT_N);
        check("busy_throughout", busy_bad, 0);

        // Interlock: arrival wins while both requests are high.
        repeat (4) step(1'b1, 1'b1, 1'b1);
        check("interlock_hold", {departing, debugState}, 4'd0);
        step(1'b1, 1'b1, 1'b0);
        check("interlock_release", departing, 1'b1);

        // Reset with the outer door commanded open, then a fresh start.
        run_until(6, 60, "reach_open_outer");
        check("open_outer_cmd", openOuter, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("reset_mid_seq", act_vec(), 9'd0);
        step(1'b1, 1'b1, 1'b0);
        check("fresh_start", debugState, 3'd1);

        // Reset during BOARD leaves the chamber pressurized: PRESSURIZE lasts one cycle.
        run_until(3, 60, "reach_board");
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("prepressurized", debugState, 3'd2);
        run_until(0, 80, "back_idle");

        // Held request: exactly one IDLE cycle between sequences.
        q = {};
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 1'b0);
            q.push_back(debugState);
        end
        gap = -1; after = -1;
        for (int i = 0; i + 1 < q.size(); i++) begin
            if (q[i] == 7 && q[i+1] == 0) begin
                int j;
                gap = 0; j = i + 1;
                while (j < q.size() && q[j] == 0) begin gap++; j++; end
                if (j < q.size()) after = q[j];
                break;
            end
        end
        check("idle_gap", gap, 1);
        check("restart_state", after, 1);

        // Stuck evacuation sensor.
        step(1'b0, 1'b0, 1'b0);
        stuck_ev = 1'b1; lvl = 1'b0; in_s = 1'b0; out_s = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        run_until(5, 60, "reach_evacuate");
        evac_len = 1; fault_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (debugState == 3'd5) evac_len++;
            if (fault) fault_cnt++;
        end
`ifdef DEPART_TIMEOUT_EN
        check("timeout_len", evac_len, TMO_N);
        check("fault_pulses", fault_cnt, 1);
        check("timeout_idle", {evacuateReq, debugState}, 4'd0);
`else
        check("wait_unbounded", debugState, 3'd5);
        check("wait_len", evac_len, 41);
        check("fault_quiet", fault_cnt, 0);
`endif
        stuck_ev = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Randomized traffic, resets and sensor noise.
        for (int b = 0; b < 25; b++) begin
            pd        = $urandom_range(1, 3);
            rand_sens = ($urandom_range(0, 3) == 0);
            stuck_ev  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 100; i++)
                step(!($urandom_range(0, 49) == 0), $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) < 2);
        end

        #5;
        check("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
